bw_io_dtl_scan_drv: RTL
=======================

Name: bw_io_dtl_scan_drv

Overview:
Serial master for a DTL IO scan-flop chain. It drives the chain's shift enable and serial input, and captures the chain's serial output. One command swaps a parallel word into the chain and returns the chain's previous contents. It sits between the IO control block and a chain of scan flops, where each flop has q, so, ck, d, se and sd, with sd fed from the previous flop's so.

Parameters:
CHAIN_LEN, 3, number of scan flops in the chain (must be >= 1)
CNT_W, $clog2(CHAIN_LEN+1), width of the shift counter (derived; do not override)

Ports:
clk  in  1  single clock; all state on rising edge
rst_l  in  1  asynchronous active-low reset
start  in  1  command request; sampled only in IDLE
wr_data  in  CHAIN_LEN  word to load; bit i lands in chain flop i (flop 0 is nearest si)
busy  out  1  high while a command is in progress
done  out  1  one-cycle pulse; rd_data valid in that cycle
rd_data  out  CHAIN_LEN  previous chain contents; bit i is the old value of flop i; held until the next done
scan_se  out  1  chain shift enable (registered)
scan_si  out  1  chain serial input (registered)
scan_so  in  1  chain serial output (last flop's so)

Behaviour:
- Reset (rst_l=0, async): state=IDLE, busy=0, done=0, scan_se=0, scan_si=0, rd_data=0, counter=0, shift register=0. Reset during SHIFT aborts immediately; scan_se drops with no clock edge; chain contents are undefined to the user.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge E0:
  - go to SHIFT; busy=1; scan_se=1; scan_si=wr_data[CHAIN_LEN-1]; counter=CHAIN_LEN.
  - load the shift register with wr_data.
- SHIFT, at each edge Ek (k=1..CHAIN_LEN):
  - the chain shifts, and scan_so is sampled into the capture register MSB-first (so bit CHAIN_LEN-k = old flop CHAIN_LEN-k).
  - counter decrements; scan_si presents the next lower wr_data bit (wr_data[CHAIN_LEN-1-k]).
- At edge E(CHAIN_LEN), counter reaches 0:
  - go to DONE; scan_se=0; scan_si=0; busy=0; done=1; rd_data=capture register.
- DONE: lasts one cycle; done=0 on exit; returns to IDLE. start is ignored in DONE.
- Latency: done is high in the cycle after edge E(CHAIN_LEN), i.e. CHAIN_LEN+1 edges after start is sampled. The next command can be accepted at the edge after done.
- scan_se is high for exactly CHAIN_LEN consecutive cycles per command.
- start while busy or in DONE: ignored, not queued.
- wr_data is only sampled at E0; changes during SHIFT have no effect.
- CHAIN_LEN=1: single shift cycle; all rules above still hold.

Optional Feature:
BW_IO_DTL_SCAN_CHK_EN
- Defined: adds output chk_err (1 bit, reset 0) and a register holding the last written word plus a valid flag (both cleared by reset).
  - At done: chk_err = valid_flag && (rd_data != last_written); valid_flag is then set and last_written updated to this command's wr_data.
  - chk_err holds until the next done. This checks chain integrity in loopback: each read must return the previous write.
- Undefined: no chk_err port and no extra registers; behaviour is otherwise identical.

Decomposition:
- Package bw_io_dtl_scan_pkg holds:
  - state enum scan_state_e {IDLE, SHIFT, DONE}
  - default CHAIN_LEN constant
- Sub-module bw_io_dtl_scan_sreg: CHAIN_LEN-bit shift register with parallel load (wr_data), serial-out MSB and serial-in capture. It is instantiated twice: once for the write path and once for the capture path.
- FSM and counter live in the top module.

Test Plan:
Bench uses a behavioural 3-flop chain model; CHAIN_LEN=3.
1. Reset, then chain preset to 3'b000; start with wr_data=3'b101 -> scan_se high 3 cycles, scan_si sequence 1,0,1; done pulse 4 edges after start; rd_data=3'b000; chain q=3'b101.
2. Back-to-back: wr_data=3'b110 issued the edge after done -> rd_data=3'b101, chain q=3'b110.
3. start held high for 10 cycles with wr_data changing mid-shift -> only one command runs, using the word sampled at E0; start is re-accepted only in IDLE.
4. rst_l pulsed low mid-SHIFT (after 2 shifts) -> scan_se, busy and done go to 0 asynchronously; rd_data=0; the next command runs normally.
5. CHK_EN: writes 3'b011, then 3'b100 with a stuck-at-0 fault injected on flop 1 -> second done gives rd_data=3'b001 and chk_err=1; first done gives chk_err=0.
6. CHAIN_LEN=1 build: wr_data=1 -> scan_se high 1 cycle; done 2 edges after start; rd_data=old chain bit.

Source files
------------

// File: rtl/bw_io_dtl_scan_pkg.sv
// Shared types and defaults for the DTL IO scan-chain serial master.
package bw_io_dtl_scan_pkg;

  localparam int CHAIN_LEN_DFLT = 3;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } scan_state_e;

endpackage

// File: rtl/bw_io_dtl_scan_drv_if.sv
// Command and scan-chain signals between the IO control block, the driver and the chain.
interface bw_io_dtl_scan_drv_if #(
  parameter int CHAIN_LEN = bw_io_dtl_scan_pkg::CHAIN_LEN_DFLT
);

  logic                 start;
  logic [CHAIN_LEN-1:0] wr_data;
  logic                 busy;
  logic                 done;
  logic [CHAIN_LEN-1:0] rd_data;
  logic                 scan_se;
  logic                 scan_si;
  logic                 scan_so;

  // master: controller plus chain side; slave: the scan driver
  modport master (
    output start, wr_data, scan_so,
    input  busy, done, rd_data, scan_se, scan_si
  );

  modport slave (
    input  start, wr_data, scan_so,
    output busy, done, rd_data, scan_se, scan_si
  );

endinterface

// File: rtl/bw_io_dtl_scan_sreg.sv
// W-bit shift register: parallel load, left shift with serial-in at bit 0.
module bw_io_dtl_scan_sreg
  import bw_io_dtl_scan_pkg::*;
#(
  parameter int W = CHAIN_LEN_DFLT
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         ld,
  input  logic [W-1:0] ld_data,
  input  logic         sh,
  input  logic         sin,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d, shl;

  generate
    if (W == 1) begin : g_one
      assign shl = sin;
    end else begin : g_multi
      assign shl = {q_q[W-2:0], sin};
    end
  endgenerate

  always_comb begin
    q_d = q_q;
    if (ld)      q_d = ld_data;
    else if (sh) q_d = shl;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/bw_io_dtl_scan_drv.sv
// Serial master for a DTL IO scan chain: swaps wr_data into the chain, returns old contents.
// Optional BW_IO_DTL_SCAN_CHK_EN adds chk_err, a loopback read-vs-previous-write check.
module bw_io_dtl_scan_drv
  import bw_io_dtl_scan_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DFLT,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_l,
`ifdef BW_IO_DTL_SCAN_CHK_EN
  output logic                  chk_err,
`endif
  bw_io_dtl_scan_drv_if.slave   bus
);

  scan_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 se_q, se_d;
  logic [CHAIN_LEN-1:0] rd_q, rd_d;
  logic                 w_ld, shift;
  logic [CHAIN_LEN-1:0] w_q, c_q;

  assign shift = (state_q == SHIFT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    se_d    = se_q;
    rd_d    = rd_q;
    w_ld    = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = SHIFT;
        cnt_d   = CNT_W'(CHAIN_LEN);
        se_d    = 1'b1;
        w_ld    = 1'b1;
      end
      SHIFT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          se_d    = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
        rd_d    = c_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      se_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      se_q    <= se_d;
      rd_q    <= rd_d;
    end
  end

  // Write path: its MSB is scan_si; zeros fill in, so si idles low after the last shift.
  bw_io_dtl_scan_sreg #(.W(CHAIN_LEN)) u_wreg (
    .clk     (clk),
    .rst_l   (rst_l),
    .ld      (w_ld),
    .ld_data (bus.wr_data),
    .sh      (shift),
    .sin     (1'b0),
    .q       (w_q)
  );

  // Capture path: scan_so enters at bit 0, so the first bit out ends up as the MSB.
  bw_io_dtl_scan_sreg #(.W(CHAIN_LEN)) u_creg (
    .clk     (clk),
    .rst_l   (rst_l),
    .ld      (1'b0),
    .ld_data ({CHAIN_LEN{1'b0}}),
    .sh      (shift),
    .sin     (bus.scan_so),
    .q       (c_q)
  );

  // Capture is complete in DONE; rd_q latches it on exit to hold until the next done.
  assign bus.rd_data = (state_q == DONE) ? c_q : rd_q;
  assign bus.busy    = shift;
  assign bus.done    = (state_q == DONE);
  assign bus.scan_se = se_q;
  assign bus.scan_si = w_q[CHAIN_LEN-1];

`ifdef BW_IO_DTL_SCAN_CHK_EN
  logic [CHAIN_LEN-1:0] cmd_q, cmd_d, last_q, last_d;
  logic                 vld_q, vld_d, chk_q, chk_d, chk_now;

  assign chk_now = vld_q && (c_q != last_q);

  always_comb begin
    cmd_d  = cmd_q;
    last_d = last_q;
    vld_d  = vld_q;
    chk_d  = chk_q;
    if (w_ld) cmd_d = bus.wr_data;
    if (state_q == DONE) begin
      chk_d  = chk_now;
      vld_d  = 1'b1;
      last_d = cmd_q;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cmd_q  <= '0;
      last_q <= '0;
      vld_q  <= 1'b0;
      chk_q  <= 1'b0;
    end else begin
      cmd_q  <= cmd_d;
      last_q <= last_d;
      vld_q  <= vld_d;
      chk_q  <= chk_d;
    end
  end

  assign chk_err = (state_q == DONE) ? chk_now : chk_q;
`endif

endmodule
